// File: rtl/ahb3lite_sram_slave_if.sv
// AHB3-Lite bus bundle between a master (or interconnect slave port) and the SRAM slave.
// Master drives address/control/write data and HREADY; slave returns data and response.
interface ahb3lite_sram_slave_if #(
  parameter int HADDR_SIZE = 16,
  parameter int HDATA_SIZE = 32
);
  logic                  HSEL;
  logic [HADDR_SIZE-1:0] HADDR;
  logic [HDATA_SIZE-1:0] HWDATA;
  logic [HDATA_SIZE-1:0] HRDATA;
  logic                  HWRITE;
  logic [2:0]            HSIZE;
  logic [2:0]            HBURST;
  logic [3:0]            HPROT;
  logic [1:0]            HTRANS;
  logic                  HMASTLOCK;
  logic                  HREADY;
  logic                  HREADYOUT;
  logic                  HRESP;

  modport master (
    output HSEL, HADDR, HWDATA, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HMASTLOCK, HREADY,
    input  HRDATA, HREADYOUT, HRESP
  );

  modport slave (
    input  HSEL, HADDR, HWDATA, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HMASTLOCK, HREADY,
    output HRDATA, HREADYOUT, HRESP
  );
endinterface

// File: rtl/ahb3lite_sram_slave.sv
// AHB3-Lite SRAM responder: byte-lane writes, programmable wait states and a
// two-cycle ERROR response for out-of-range, oversized or misaligned transfers.
module ahb3lite_sram_slave #(
  parameter int HADDR_SIZE = 16,
  parameter int HDATA_SIZE = 32,
  parameter int MEM_DEPTH  = 256
) (
  input  logic                 HCLK,
  input  logic                 HRESET,
  input  logic [2:0]           wait_cfg,
  ahb3lite_sram_slave_if.slave bus
);
  localparam int BYTES = HDATA_SIZE / 8;
  localparam int ALSB  = $clog2(BYTES);
  localparam int IW    = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_WAIT = 3'd1;
  localparam logic [2:0] ST_LAST = 3'd2;
  localparam logic [2:0] ST_ERR1 = 3'd3;
  localparam logic [2:0] ST_ERR2 = 3'd4;

  function automatic logic [BYTES-1:0] lane_enable(input logic [2:0] size,
                                                   input logic [ALSB-1:0] low);
    int n;
    lane_enable = '0;
    n = 32'sd1 << size;
    for (int b = 0; b < BYTES; b++) begin
      lane_enable[b] = (b >= int'(low)) && (b < int'(low) + n);
    end
  endfunction

  function automatic logic is_misaligned(input logic [2:0] size,
                                         input logic [ALSB-1:0] low);
    int n;
    n = 32'sd1 << size;
    return (int'(low) & (n - 32'sd1)) != 32'sd0;
  endfunction

  logic [2:0]                 r_state;
  logic [2:0]                 w_next_state;
  logic [2:0]                 r_cnt;
  logic [2:0]                 w_next_cnt;
  logic [IW-1:0]              r_widx;
  logic [BYTES-1:0]           r_be;
  logic                       r_write;
  logic                       r_hreadyout;
  logic                       r_hresp;
  logic [HDATA_SIZE-1:0]      r_mem [MEM_DEPTH];
  logic [HDATA_SIZE-1:0]      w_rdata;
  logic [HADDR_SIZE-ALSB-1:0] w_word_idx;
  logic                       w_can_accept;
  logic                       w_accept;
  logic                       w_err;
  logic                       w_unused;

  assign w_word_idx   = bus.HADDR[HADDR_SIZE-1:ALSB];
  // Only states that drive HREADYOUT high can overlap a new address phase.
  assign w_can_accept = (r_state == ST_IDLE) || (r_state == ST_LAST) || (r_state == ST_ERR2);
  assign w_accept     = w_can_accept & bus.HSEL & bus.HREADY & bus.HTRANS[1];
  assign w_err        = (int'(w_word_idx) >= MEM_DEPTH)
                     || (int'(bus.HSIZE) > ALSB)
                     || is_misaligned(bus.HSIZE, bus.HADDR[ALSB-1:0]);
  assign w_unused     = ^{bus.HBURST, bus.HPROT, bus.HMASTLOCK, bus.HTRANS[0]};

  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    case (r_state)
      ST_IDLE, ST_LAST, ST_ERR2: begin
        if (w_accept) begin
          if (w_err) begin
            w_next_state = ST_ERR1;
            w_next_cnt   = 3'd0;
          end else if (wait_cfg == 3'd0) begin
            w_next_state = ST_LAST;
            w_next_cnt   = 3'd0;
          end else begin
            w_next_state = ST_WAIT;
            w_next_cnt   = wait_cfg;
          end
        end else begin
          w_next_state = ST_IDLE;
          w_next_cnt   = 3'd0;
        end
      end
      ST_WAIT: begin
        if (r_cnt <= 3'd1) begin
          w_next_state = ST_LAST;
          w_next_cnt   = 3'd0;
        end else begin
          w_next_state = ST_WAIT;
          w_next_cnt   = r_cnt - 3'd1;
        end
      end
      ST_ERR1: begin
        w_next_state = ST_ERR2;
        w_next_cnt   = 3'd0;
      end
      default: begin
        w_next_state = ST_IDLE;
        w_next_cnt   = 3'd0;
      end
    endcase
  end

  // Responses are decoded from the next state so they come straight off flops.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_state     <= ST_IDLE;
      r_cnt       <= 3'd0;
      r_hreadyout <= 1'b1;
      r_hresp     <= 1'b0;
      r_widx      <= '0;
      r_be        <= '0;
      r_write     <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_cnt       <= w_next_cnt;
      r_hreadyout <= !((w_next_state == ST_WAIT) || (w_next_state == ST_ERR1));
      r_hresp     <= (w_next_state == ST_ERR1) || (w_next_state == ST_ERR2);
      if (w_accept) begin
        r_widx  <= w_word_idx[IW-1:0];
        r_write <= bus.HWRITE;
        r_be    <= lane_enable(bus.HSIZE, bus.HADDR[ALSB-1:0]);
      end
    end
  end

  // Write data is committed on the edge that closes LAST; errored writes never get there.
  always_ff @(posedge HCLK) begin
    if (!HRESET && (r_state == ST_LAST) && r_write) begin
      for (int b = 0; b < BYTES; b++) begin
        if (r_be[b]) begin
          r_mem[r_widx][8*b +: 8] <= bus.HWDATA[8*b +: 8];
        end
      end
    end
  end

  always_comb begin
    if (!r_write && ((r_state == ST_WAIT) || (r_state == ST_LAST))) begin
      w_rdata = r_mem[r_widx];
    end else begin
      w_rdata = '0;
    end
  end

  assign bus.HRDATA    = w_rdata;
  assign bus.HREADYOUT = r_hreadyout;
  assign bus.HRESP     = r_hresp;
endmodule

// File: tb/tb_ahb3lite_sram_slave.sv
// Self-checking bench for ahb3lite_sram_slave against a byte-array reference model.
module tb_ahb3lite_sram_slave;
  logic       clk;
  logic       rst;
  logic [2:0] wait_cfg;
  int         total;
  int         bad;
  logic [7:0] mem_m [0:1023];

  ahb3lite_sram_slave_if #(.HADDR_SIZE(16), .HDATA_SIZE(32)) bus ();
  assign bus.HREADY = bus.HREADYOUT;

  ahb3lite_sram_slave #(.HADDR_SIZE(16), .HDATA_SIZE(32), .MEM_DEPTH(256)) dut (
    .HCLK(clk), .HRESET(rst), .wait_cfg(wait_cfg), .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit exp_err(input logic [15:0] addr, input logic [2:0] size);
    int n;
    n = 1 << size;
    return ((int'(addr) / 4) >= 256) || (size > 3'd2) || ((int'(addr) % n) != 0);
  endfunction

  function automatic logic [31:0] model_word(input logic [15:0] addr);
    int w;
    w = (int'(addr) / 4) * 4;
    return {mem_m[w+3], mem_m[w+2], mem_m[w+1], mem_m[w]};
  endfunction

  task automatic model_write(input logic [15:0] addr, input logic [2:0] size, input logic [31:0] wdata);
    int a;
    for (int k = 0; k < (1 << size); k++) begin
      a = int'(addr) + k;
      mem_m[a] = wdata[8*(a%4) +: 8];
    end
  endtask

  task automatic bus_idle();
    bus.HSEL = 1'b0; bus.HTRANS = 2'd0; bus.HADDR = '0; bus.HWRITE = 1'b0;
    bus.HSIZE = 3'd0; bus.HBURST = 3'd0; bus.HPROT = 4'd0; bus.HMASTLOCK = 1'b0;
  endtask

  // One non-pipelined transfer; reports data-phase low cycles, response and final read data.
  task automatic do_xfer(input bit wr, input logic [15:0] addr, input logic [2:0] size,
                         input logic [31:0] wdata, input logic [2:0] cfg,
                         output int waits, output logic resp_lo, output logic resp_hi,
                         output logic [31:0] rdata);
    bus.HSEL = 1'b1; bus.HTRANS = 2'd2; bus.HADDR = addr; bus.HWRITE = wr; bus.HSIZE = size;
    bus.HBURST = 3'($urandom); bus.HPROT = 4'($urandom); bus.HMASTLOCK = 1'($urandom);
    wait_cfg = cfg;
    @(posedge clk); #1;
    bus_idle();
    bus.HWDATA = wdata;
    wait_cfg = 3'd0;
    waits = 0; resp_lo = 1'b0; resp_hi = 1'b0; rdata = '0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.HREADYOUT) begin
        resp_hi = bus.HRESP; rdata = bus.HRDATA;
        @(posedge clk); #1;
        return;
      end
      waits++;
      resp_lo = resp_lo | bus.HRESP;
      @(posedge clk); #1;
    end
    waits = -1;
  endtask

  task automatic test_reset();
    rst = 1'b1; bus_idle(); bus.HWDATA = '0; wait_cfg = 3'd0;
    repeat (2) @(posedge clk);
    #1;
    total++; if (bus.HREADYOUT !== 1'b1) begin bad++; $display("FAIL reset_hreadyout got=%b exp=1", bus.HREADYOUT); end
    total++; if (bus.HRESP !== 1'b0) begin bad++; $display("FAIL reset_hresp got=%b exp=0", bus.HRESP); end
    total++; if (bus.HRDATA !== 32'h0) begin bad++; $display("FAIL reset_hrdata got=%h exp=0", bus.HRDATA); end
    rst = 1'b0; bus.HSEL = 1'b1; bus.HTRANS = 2'd0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      total++; if (bus.HREADYOUT !== 1'b1 || bus.HRESP !== 1'b0) begin
        bad++; $display("FAIL idle_okay got=%b/%b exp=1/0", bus.HREADYOUT, bus.HRESP);
      end
    end
    bus_idle();
  endtask

  task automatic test_init();
    int w; logic rl, rh; logic [31:0] rd, d;
    for (int i = 0; i < 64; i++) begin
      d = $urandom;
      do_xfer(1'b1, 16'(i*4), 3'd2, d, 3'd0, w, rl, rh, rd);
      model_write(16'(i*4), 3'd2, d);
      total++; if (w !== 0 || rh !== 1'b0) begin bad++; $display("FAIL init_write i=%0d waits=%0d resp=%b exp 0/0", i, w, rh); end
    end
    for (int i = 0; i < 64; i += 9) begin
      do_xfer(1'b0, 16'(i*4), 3'd2, 32'h0, 3'd0, w, rl, rh, rd);
      total++; if (rd !== model_word(16'(i*4))) begin bad++; $display("FAIL init_read i=%0d got=%h exp=%h", i, rd, model_word(16'(i*4))); end
    end
  endtask

  task automatic test_write_read();
    bus.HSEL = 1'b1; bus.HTRANS = 2'd2; bus.HADDR = 16'h0010; bus.HWRITE = 1'b1; bus.HSIZE = 3'd2; wait_cfg = 3'd0;
    @(posedge clk); #1;
    bus.HWDATA = 32'hDEADBEEF; bus.HWRITE = 1'b0;
    total++; if (bus.HREADYOUT !== 1'b1) begin bad++; $display("FAIL b2b_wr_ready got=%b exp=1", bus.HREADYOUT); end
    @(posedge clk); #1;
    model_write(16'h0010, 3'd2, 32'hDEADBEEF);
    bus_idle();
    total++; if (bus.HREADYOUT !== 1'b1) begin bad++; $display("FAIL b2b_rd_ready got=%b exp=1", bus.HREADYOUT); end
    total++; if (bus.HRDATA !== model_word(16'h0010)) begin bad++; $display("FAIL b2b_rdata got=%h exp=%h", bus.HRDATA, model_word(16'h0010)); end
    @(posedge clk); #1;
    total++; if (bus.HRDATA !== 32'h0) begin bad++; $display("FAIL b2b_idle_rdata got=%h exp=0", bus.HRDATA); end
  endtask

  task automatic test_byte_lanes();
    int w; logic rl, rh; logic [31:0] rd;
    do_xfer(1'b1, 16'h0020, 3'd2, 32'h00000000, 3'd0, w, rl, rh, rd); model_write(16'h0020, 3'd2, 32'h00000000);
    do_xfer(1'b1, 16'h0021, 3'd0, 32'h0000AA00, 3'd1, w, rl, rh, rd); model_write(16'h0021, 3'd0, 32'h0000AA00);
    do_xfer(1'b1, 16'h0022, 3'd1, 32'h55550000, 3'd0, w, rl, rh, rd); model_write(16'h0022, 3'd1, 32'h55550000);
    do_xfer(1'b0, 16'h0020, 3'd2, 32'hFFFFFFFF, 3'd0, w, rl, rh, rd);
    total++; if (rd !== 32'h5555AA00) begin bad++; $display("FAIL byte_lanes got=%h exp=5555aa00", rd); end
    total++; if (rd !== model_word(16'h0020)) begin bad++; $display("FAIL byte_lanes_model got=%h exp=%h", rd, model_word(16'h0020)); end
  endtask

  task automatic test_wait_states();
    int w; logic rl, rh; logic [31:0] rd;
    do_xfer(1'b0, 16'h0004, 3'd2, 32'h0, 3'd3, w, rl, rh, rd);
    total++; if (w !== 3) begin bad++; $display("FAIL wait3_cycles got=%0d exp=3", w); end
    total++; if (rd !== model_word(16'h0004) || rh !== 1'b0) begin bad++; $display("FAIL wait3_data got=%h/%b exp=%h/0", rd, rh, model_word(16'h0004)); end
    do_xfer(1'b0, 16'h0008, 3'd2, 32'h0, 3'd7, w, rl, rh, rd);
    total++; if (w !== 7) begin bad++; $display("FAIL wait7_cycles got=%0d exp=7", w); end
  endtask

  task automatic test_error();
    int w; logic rl, rh; logic [31:0] rd;
    do_xfer(1'b0, 16'h0400, 3'd2, 32'h0, 3'd4, w, rl, rh, rd);
    total++; if (w !== 1 || rl !== 1'b1) begin bad++; $display("FAIL err_oob_first waits=%0d resp=%b exp 1/1", w, rl); end
    total++; if (rh !== 1'b1 || rd !== 32'h0) begin bad++; $display("FAIL err_oob_second resp=%b rdata=%h exp 1/0", rh, rd); end
    @(negedge clk);
    total++; if (bus.HREADYOUT !== 1'b1 || bus.HRESP !== 1'b0) begin bad++; $display("FAIL err_then_okay got=%b/%b exp=1/0", bus.HREADYOUT, bus.HRESP); end
    @(posedge clk); #1;
    do_xfer(1'b1, 16'h0001, 3'd1, 32'hFFFFFFFF, 3'd0, w, rl, rh, rd);
    total++; if (w !== 1 || rl !== 1'b1 || rh !== 1'b1) begin bad++; $display("FAIL err_misalign got=%0d/%b/%b exp=1/1/1", w, rl, rh); end
    do_xfer(1'b1, 16'h0000, 3'd3, 32'hFFFFFFFF, 3'd0, w, rl, rh, rd);
    total++; if (w !== 1 || rh !== 1'b1) begin bad++; $display("FAIL err_size got=%0d/%b exp=1/1", w, rh); end
    do_xfer(1'b0, 16'h0000, 3'd2, 32'h0, 3'd0, w, rl, rh, rd);
    total++; if (rd !== model_word(16'h0000)) begin bad++; $display("FAIL err_mem_kept got=%h exp=%h", rd, model_word(16'h0000)); end
  endtask

  task automatic test_reset_mid_wait();
    int w; logic rl, rh; logic [31:0] rd, old;
    old = model_word(16'h0008);
    bus.HSEL = 1'b1; bus.HTRANS = 2'd2; bus.HADDR = 16'h0008; bus.HWRITE = 1'b1; bus.HSIZE = 3'd2; wait_cfg = 3'd5;
    @(posedge clk); #1;
    bus_idle(); bus.HWDATA = ~old;
    total++; if (bus.HREADYOUT !== 1'b0) begin bad++; $display("FAIL rstw_waiting got=%b exp=0", bus.HREADYOUT); end
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    total++; if (bus.HREADYOUT !== 1'b1 || bus.HRESP !== 1'b0 || bus.HRDATA !== 32'h0) begin
      bad++; $display("FAIL rstw_outputs got=%b/%b/%h exp=1/0/0", bus.HREADYOUT, bus.HRESP, bus.HRDATA);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    do_xfer(1'b0, 16'h0008, 3'd2, 32'h0, 3'd0, w, rl, rh, rd);
    total++; if (rd !== old || w !== 0) begin bad++; $display("FAIL rstw_old_data got=%h/%0d exp=%h/0", rd, w, old); end
  endtask

  task automatic test_random();
    int w, expw; logic rl, rh; logic [31:0] rd, d, exp_rd; logic [15:0] a; logic [2:0] sz, cfg; bit wr, e;
    for (int i = 0; i < 60; i++) begin
      wr  = 1'($urandom);
      a   = ($urandom_range(99, 0) < 12) ? 16'(16'h0400 + $urandom_range(4095, 0)) : 16'($urandom_range(255, 0));
      sz  = ($urandom_range(9, 0) == 0) ? 3'($urandom_range(7, 3)) : 3'($urandom_range(2, 0));
      cfg = 3'($urandom);
      d   = $urandom;
      e   = exp_err(a, sz);
      expw   = e ? 1 : int'(cfg);
      exp_rd = (!e && !wr) ? model_word(a) : 32'h0;
      do_xfer(wr, a, sz, d, cfg, w, rl, rh, rd);
      if (!e && wr) model_write(a, sz, d);
      total++; if (w !== expw) begin bad++; $display("FAIL rnd_waits i=%0d a=%h sz=%0d got=%0d exp=%0d", i, a, sz, w, expw); end
      total++; if (rl !== (e && 1'b1) || rh !== (e && 1'b1)) begin bad++; $display("FAIL rnd_resp i=%0d a=%h got=%b/%b exp=%b", i, a, rl, rh, e); end
      total++; if (rd !== exp_rd) begin bad++; $display("FAIL rnd_rdata i=%0d a=%h got=%h exp=%h", i, a, rd, exp_rd); end
    end
  endtask

  initial begin
    total = 0; bad = 0;
    test_reset();
    test_init();
    test_write_read();
    test_byte_lanes();
    test_wait_states();
    test_error();
    test_reset_mid_wait();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ahb3lite_sram_slave.md
Name: ahb3lite_sram_slave

Overview:
AHB3-Lite slave responder: an on-chip SRAM model with byte-lane writes, programmable wait states and a two-cycle ERROR response. It sits on a slave port of ahb3lite_interconnect, at the far end from the bus masters, and answers their transfers. It is used as the standard memory target in interconnect benches and as a small scratch RAM in designs.

Parameters:
HADDR_SIZE, 16, address width
HDATA_SIZE, 32, data width (32 or 64)
MEM_DEPTH, 256, memory size in HDATA_SIZE-bit words

Ports:
HCLK  in  1  bus clock, rising edge
HRESET  in  1  asynchronous reset, active-high
HSEL  in  1  slave select from interconnect
HADDR  in  HADDR_SIZE  address (address phase)
HWDATA  in  HDATA_SIZE  write data (data phase)
HRDATA  out  HDATA_SIZE  read data
HWRITE  in  1  1=write
HSIZE  in  3  transfer size
HBURST  in  3  ignored
HPROT  in  4  ignored
HTRANS  in  2  0 IDLE, 1 BUSY, 2 NONSEQ, 3 SEQ
HMASTLOCK  in  1  ignored
HREADY  in  1  bus-wide ready
HREADYOUT  out  1  slave ready
HRESP  out  1  0 OKAY, 1 ERROR
wait_cfg  in  3  wait states inserted per transfer (0-7)

Behaviour:
- Reset (asynchronous, HRESET=1): state IDLE, HREADYOUT=1, HRESP=0, HRDATA=0, wait counter=0. Memory contents are not reset. Reset during a wait or error phase aborts the transfer with no memory write.
- Accept: on a rising edge with HSEL & HREADY & HTRANS[1]. This latches addr, write, size and wait_cfg. IDLE/BUSY, or HSEL=0, gives a zero-wait OKAY data phase.
- Error check at accept. Any of the following routes the transfer to ERR1:
  - word index (HADDR >> log2(HDATA_SIZE/8)) >= MEM_DEPTH
  - HSIZE > log2(HDATA_SIZE/8)
  - HADDR not aligned to 2^HSIZE
- FSM states IDLE, WAIT, LAST, ERR1, ERR2:
  - IDLE: HREADYOUT=1, HRESP=0.
  - Accept OK with wait=0 -> LAST. Accept OK with wait=N>0 -> WAIT, counter=N.
  - WAIT: HREADYOUT=0; counter decrements each cycle; at 1 -> LAST.
  - LAST: HREADYOUT=1, HRESP=0; data-phase completion cycle. A new accept in this same cycle is allowed (pipelined) and follows the rules above. Otherwise -> IDLE.
  - ERR1: HREADYOUT=0, HRESP=1 -> ERR2.
  - ERR2: HREADYOUT=1, HRESP=1. A new accept in this cycle is allowed. ERR2 is always entered even if the master drives IDLE during ERR1.
- Latency: data-phase length = wait_cfg+1 cycles for OKAY, exactly 2 cycles for ERROR. A wait_cfg change after accept has no effect on the current transfer.
- Write commit: HWDATA is sampled at the rising edge that ends LAST. Only byte lanes selected by size/addr[low] are written, little-endian. Byte: lane addr[1:0] (addr[2:0] for 64-bit). Halfword: lanes {a,a+1}. Word/dword: all selected lanes. Errored writes never modify memory.
- Read data: HRDATA = memory word at the latched word index during WAIT/LAST of a read, full word on all lanes; 0 otherwise. The read is combinational from the array, so back-to-back write-then-read to the same address returns the newly written data with no stall.
- HBURST, HPROT and HMASTLOCK are accepted and ignored. Bursts are handled as consecutive single transfers.

Test Plan:
- Reset then idle: HRESET pulse -> HREADYOUT=1, HRESP=0, HRDATA=0. HTRANS=IDLE with HSEL=1 -> HREADYOUT stays 1.
- Write then read, wait_cfg=0: word write 0xDEADBEEF @0x0010, then pipelined word read @0x0010 -> HRDATA=0xDEADBEEF in the cycle after the read address phase, HREADYOUT never low.
- Byte lanes: word write 0x00000000 @0x20; byte write 0xAA in lane 1 @0x21; halfword write 0x5555 in upper half @0x22; read @0x20 -> 0x5555AA00.
- Wait states: wait_cfg=3, read @0x04 -> HREADYOUT low for exactly 3 cycles then high with data. Changing wait_cfg to 0 mid-transfer does not shorten it.
- Error: read @0x0400 with MEM_DEPTH=256 -> HREADYOUT=0/HRESP=1, then HREADYOUT=1/HRESP=1, then OKAY. A misaligned halfword write @0x0001 also errors and memory stays unchanged.
- Reset mid-wait: wait_cfg=5 write @0x08, HRESET asserted during the 2nd wait cycle -> outputs at reset values immediately, and a later read @0x08 returns the old contents.
